// File: rtl/regs_dump_reader.sv
// Sweeps the register file on a start pulse and streams every word MSB-first as hex nibbles.
// Optional REGS_DUMP_SKIP_ZERO_EN: all-zero registers are skipped, out_last marks the last emitted nibble.
module regs_dump_reader #(
   parameter int AW    = 3,
   parameter int NREGS = 8,
   parameter int DW    = 32,
   localparam int ND   = DW / 4,
   localparam int PW   = (ND > 1) ? $clog2(ND) : 1
) (
   input  logic          clk,
   input  logic          cr,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [AW-1:0] rd_addr,
   input  logic [DW-1:0] rd_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [3:0]    out_nib,
   output logic [AW-1:0] out_reg,
   output logic [PW-1:0] out_pos,
   output logic          out_last
);

   typedef enum logic [1:0] {IDLE, FETCH, EMIT, DONE} state_t;

   localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);
   localparam logic [PW-1:0] LAST_POS = PW'(ND - 1);

   state_t        state_q, state_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [AW-1:0] rd_addr_q, rd_addr_d;
   logic [DW-1:0] shreg_q, shreg_d;
   logic [PW-1:0] pos_q, pos_d;
   logic          accept, word_end, last_reg;

   assign accept   = (state_q == EMIT) && out_ready;
   assign word_end = (pos_q == LAST_POS);
   assign last_reg = (idx_q == LAST_IDX);

`ifdef REGS_DUMP_SKIP_ZERO_EN
   // While a word is emitted, the idle read port probes the registers after it
   // so out_last can tell whether any later register will still be emitted.
   localparam logic [AW:0] PROBE_END = (AW + 1)'(NREGS);
   localparam logic [AW:0] PROBE_LAST = {1'b0, LAST_IDX};

   logic [AW:0] probe_q, probe_d;
   logic        nz_q, nz_d;
   logic        probing;

   assign probing = (state_q == EMIT) && (probe_q != PROBE_END);
`endif

   always_ff @(posedge clk) begin
      if (!cr) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         rd_addr_q <= '0;
         shreg_q   <= '0;
         pos_q     <= '0;
`ifdef REGS_DUMP_SKIP_ZERO_EN
         probe_q   <= PROBE_END;
         nz_q      <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         rd_addr_q <= rd_addr_d;
         shreg_q   <= shreg_d;
         pos_q     <= pos_d;
`ifdef REGS_DUMP_SKIP_ZERO_EN
         probe_q   <= probe_d;
         nz_q      <= nz_d;
`endif
      end
   end

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      rd_addr_d = rd_addr_q;
      shreg_d   = shreg_q;
      pos_d     = pos_q;
`ifdef REGS_DUMP_SKIP_ZERO_EN
      probe_d   = probe_q;
      nz_d      = nz_q;
`endif

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = FETCH;
               idx_d     = '0;
               rd_addr_d = '0;
            end
         end

         FETCH: begin
            shreg_d = rd_data;
            pos_d   = '0;
            state_d = EMIT;
`ifdef REGS_DUMP_SKIP_ZERO_EN
            if (rd_data == '0) begin
               if (last_reg) begin
                  state_d = DONE;
               end else begin
                  idx_d     = idx_q + 1'b1;
                  rd_addr_d = idx_q + 1'b1;
                  state_d   = FETCH;
               end
            end else begin
               nz_d = 1'b0;
               if (last_reg) begin
                  probe_d = PROBE_END;
               end else begin
                  probe_d   = {1'b0, idx_q} + 1'b1;
                  rd_addr_d = idx_q + 1'b1;
               end
            end
`endif
         end

         EMIT: begin
`ifdef REGS_DUMP_SKIP_ZERO_EN
            if (probing) begin
               nz_d    = nz_q | (rd_data != '0);
               probe_d = probe_q + 1'b1;
               if (probe_q != PROBE_LAST) begin
                  rd_addr_d = rd_addr_q + 1'b1;
               end
            end
`endif
            if (accept) begin
               shreg_d = shreg_q << 4;
               pos_d   = pos_q + 1'b1;
               if (word_end) begin
                  pos_d = '0;
                  if (last_reg) begin
                     state_d = DONE;
                  end else begin
                     idx_d     = idx_q + 1'b1;
                     rd_addr_d = idx_q + 1'b1;
                     state_d   = FETCH;
                  end
               end
            end
         end

         DONE: begin
            idx_d     = '0;
            rd_addr_d = '0;
            state_d   = IDLE;
         end

         default: state_d = IDLE;
      endcase
   end

   assign busy      = (state_q != IDLE);
   assign done      = (state_q == DONE);
   assign out_valid = (state_q == EMIT);
   assign rd_addr   = rd_addr_q;
   assign out_nib   = out_valid ? shreg_q[DW-1 -: 4] : 4'h0;
   assign out_reg   = out_valid ? idx_q : '0;
   assign out_pos   = out_valid ? pos_q : '0;

`ifdef REGS_DUMP_SKIP_ZERO_EN
   assign out_last = out_valid && word_end &&
                     (last_reg ||
                      ((probe_q == PROBE_END) && !nz_q) ||
                      ((probe_q == PROBE_LAST) && !nz_q && (rd_data == '0)));
`else
   assign out_last = out_valid && word_end && last_reg;
`endif

endmodule

// File: tb/tb_regs_dump_reader.sv
// Randomized self-checking bench for regs_dump_reader against a nibble-list reference model.
// Honours REGS_DUMP_SKIP_ZERO_EN in the model when the design is built with it.
module tb_regs_dump_reader;

   localparam int AW    = 3;
   localparam int NREGS = 8;
   localparam int DW    = 32;
   localparam int ND    = DW / 4;
`ifdef REGS_DUMP_SKIP_ZERO_EN
   localparam int FULL_LEN = 0;
`else
   localparam int FULL_LEN = NREGS * (1 + ND) + 1;
`endif

   logic          clk = 1'b0;
   logic          cr;
   logic          start;
   logic          busy, done, out_valid, out_ready, out_last;
   logic [AW-1:0] rd_addr, out_reg;
   logic [DW-1:0] rd_data;
   logic [3:0]    out_nib;
   logic [2:0]    out_pos;

   logic [DW-1:0] regs [NREGS];

   int vectors     = 0;
   int miscompares = 0;

   logic [3:0] exp_nib  [$];
   int         exp_reg  [$];
   int         exp_pos  [$];
   bit         exp_last [$];

   regs_dump_reader dut (
      .clk       (clk),
      .cr        (cr),
      .start     (start),
      .busy      (busy),
      .done      (done),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_nib   (out_nib),
      .out_reg   (out_reg),
      .out_pos   (out_pos),
      .out_last  (out_last)
   );

   always #5 clk = ~clk;

   assign rd_data = regs[rd_addr];

   task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Expected stream: every (emitted) register contributes ND nibbles, MSB first.
   function automatic void build_expected();
      exp_nib.delete();
      exp_reg.delete();
      exp_pos.delete();
      exp_last.delete();
      for (int i = 0; i < NREGS; i++) begin
`ifdef REGS_DUMP_SKIP_ZERO_EN
         if (regs[i] == 0) continue;
`endif
         for (int p = 0; p < ND; p++) begin
            exp_nib.push_back(4'((regs[i] >> (4 * (ND - 1 - p))) & 32'hF));
            exp_reg.push_back(i);
            exp_pos.push_back(p);
            exp_last.push_back(1'b0);
         end
      end
      if (exp_last.size() > 0) exp_last[exp_last.size() - 1] = 1'b1;
   endfunction

   function automatic logic next_ready(input bit rand_ready);
      return rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   endfunction

   task automatic check_all_zero(input string tag);
      checkOutput(tag, 64'({busy, done, out_valid, out_last, out_nib, out_reg, out_pos, rd_addr}), 64'd0);
   endtask

   // One dump: start pulse (or held start), stream checked against the model,
   // optional reset abort when register abort_reg is being emitted.
   task automatic applyStimulus(input bit rand_ready, input bit hold_start,
                                input int abort_reg, input int exp_done_cycle);
      bit          stalled  = 1'b0;
      bit          finished = 1'b0;
      logic [63:0] held     = '0;
      build_expected();
      @(posedge clk);
      #1 start = 1'b1;
      out_ready = next_ready(rand_ready);
      @(posedge clk);
      #1 if (!hold_start) start = 1'b0;
      out_ready = next_ready(rand_ready);
      for (int n = 0; n < 3000 && !finished; n++) begin
         @(negedge clk);
         if (stalled)
            checkOutput("stable_on_stall", 64'({out_valid, out_nib, out_reg, out_pos, out_last}), held);
         stalled = out_valid && !out_ready;
         held    = 64'({out_valid, out_nib, out_reg, out_pos, out_last});
         if (out_valid && out_ready) begin
            if (exp_nib.size() == 0) begin
               checkOutput("extra_nibble", 64'd1, 64'd0);
            end else begin
               checkOutput("nib",  64'(out_nib),  64'(exp_nib.pop_front()));
               checkOutput("reg",  64'(out_reg),  64'(exp_reg.pop_front()));
               checkOutput("pos",  64'(out_pos),  64'(exp_pos.pop_front()));
               checkOutput("last", 64'(out_last), 64'(exp_last.pop_front()));
            end
         end
         if (abort_reg >= 0 && out_valid && out_reg == AW'(abort_reg)) begin
            cr = 1'b0;
            @(posedge clk);
            @(negedge clk);
            check_all_zero("abort_outputs");
            cr = 1'b1;
            finished = 1'b1;
         end else if (done) begin
            finished = 1'b1;
            if (exp_done_cycle > 0) checkOutput("done_cycle", 64'(n + 1), 64'(exp_done_cycle));
            checkOutput("nibbles_left", 64'(exp_nib.size()), 64'd0);
         end
         if (!finished) begin
            @(posedge clk);
            #1 out_ready = next_ready(rand_ready);
         end
      end
      if (!finished) checkOutput("timeout", 64'd1, 64'd0);
      @(posedge clk);
      #1 start = 1'b0;
      out_ready = 1'b1;
      repeat (3) begin
         @(negedge clk);
         checkOutput("idle_after", 64'({busy, done, out_valid}), 64'd0);
      end
   endtask

   task automatic fill_random();
      for (int i = 0; i < NREGS; i++) regs[i] = $urandom;
   endtask

   initial begin
      for (int i = 0; i < NREGS; i++) regs[i] = '0;
      cr        = 1'b0;
      start     = 1'b1;
      out_ready = 1'b1;

      // Reset held with start asserted, then released with start low.
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset_outputs");
      start = 1'b0;
      cr    = 1'b1;
      repeat (2) begin
         @(negedge clk);
         checkOutput("idle_after_reset", 64'({busy, out_valid, done}), 64'd0);
      end

      for (int i = 0; i < NREGS; i++) regs[i] = 32'h1111_1111 * i;
      applyStimulus(1'b0, 1'b0, -1, FULL_LEN);

      fill_random();
      regs[5] = 32'hDEAD_BEEF;
      applyStimulus(1'b1, 1'b0, -1, 0);

      fill_random();
      applyStimulus(1'b1, 1'b1, -1, 0);

      fill_random();
      applyStimulus(1'b0, 1'b0, 4, 0);
      applyStimulus(1'b0, 1'b0, -1, FULL_LEN);

      for (int i = 0; i < NREGS; i++) regs[i] = '0;
      regs[2] = 32'h0000_00A5;
      regs[6] = 32'h8000_0000;
      applyStimulus(1'b1, 1'b0, -1, 0);

      for (int i = 0; i < NREGS; i++) regs[i] = '0;
      applyStimulus(1'b0, 1'b0, -1, FULL_LEN);

      for (int k = 0; k < 4; k++) begin
         fill_random();
         if (k[0]) regs[$urandom_range(0, NREGS - 1)] = '0;
         applyStimulus(1'b1, 1'b0, -1, 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
